// File: rtl/alu_rr_arbiter_if.sv
// Command/response bundle between two ALU requesters, the arbiter and one response consumer.
interface alu_rr_arbiter_if #(
  parameter int n = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [n-1:0] req0_op1;
  logic [n-1:0] req0_op2;
  logic [2:0]   req0_ctrl;
  logic         req1_valid;
  logic         req1_ready;
  logic [n-1:0] req1_op1;
  logic [n-1:0] req1_op2;
  logic [2:0]   req1_ctrl;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [n-1:0] rsp_result;
  logic         rsp_zero;
  logic         busy;

  // Requester/consumer side
  modport master (
    output req0_valid, req0_op1, req0_op2, req0_ctrl,
    output req1_valid, req1_op1, req1_op2, req1_ctrl,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, busy
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_ctrl,
    input  req1_valid, req1_op1, req1_op2, req1_ctrl,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, busy
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// One command in flight: IDLE (grant/capture) -> EXEC (compute) -> RESP (hold until taken).
module alu_rr_arbiter #(
  parameter int n = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state, state_nxt;
  logic         last_grant;
  logic         grant_vld;
  logic         grant_id;

  logic [n-1:0] op1_p0;
  logic [n-1:0] op2_p0;
  logic [2:0]   ctrl_p0;
  logic         id_p0;

  logic [n-1:0] alu_res;
  logic [n-1:0] res_p1;
  logic         zero_p1;
  logic         id_p1;

  // All results wrap modulo 2^n; shifts fill with zeros.
  function automatic logic [n-1:0] alu_op(input logic [2:0] ctrl,
                                          input logic [n-1:0] a,
                                          input logic [n-1:0] b);
    logic [n-1:0] r;
    case (ctrl)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = a << 2;
      3'b110:  r = a >> 2;
      default: r = a + {{(n-1){1'b0}}, 1'b1};
    endcase
    return r;
  endfunction

  // Next state, round-robin grant and combinational ready strobes.
  // Grants are masked while rst_n is low so ready can never rise during reset.
  always_comb begin
    state_nxt      = state;
    grant_vld      = 1'b0;
    grant_id       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (bus.req0_valid && bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant;
          end else if (bus.req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
          end else if (bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
          end
        end
        bus.req0_ready = grant_vld & ~grant_id;
        bus.req1_ready = grant_vld &  grant_id;
        if (grant_vld) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and last-grant pointer; pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_vld) last_grant <= grant_id;
    end
  end

  // ---- stage p0: capture the granted command so later requester changes cannot leak in ----
  always_ff @(posedge clk) begin
    if (grant_vld) begin
      op1_p0  <= grant_id ? bus.req1_op1  : bus.req0_op1;
      op2_p0  <= grant_id ? bus.req1_op2  : bus.req0_op2;
      ctrl_p0 <= grant_id ? bus.req1_ctrl : bus.req0_ctrl;
      id_p0   <= grant_id;
    end
  end

  assign alu_res = alu_op(ctrl_p0, op1_p0, op2_p0);

  // ---- stage p1: register result in EXEC; held untouched outside EXEC ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      id_p1   <= 1'b0;
    end else if (state == EXEC) begin
      res_p1  <= alu_res;
      zero_p1 <= (alu_res == '0);
      id_p1   <= id_p0;
    end
  end

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_result = res_p1;
  assign bus.rsp_zero   = zero_p1;
  assign bus.rsp_id     = id_p1;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with hand-computed expected values.
module tb_alu_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_rr_arbiter_if #(.n(32)) bus ();

  alu_rr_arbiter #(.n(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-requester command with rsp_ready held high; called at posedge+1 in IDLE.
  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c, input logic [31:0] exp, input logic expz);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_ctrl = c;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_ctrl = c;
    end
    #1;
    chk("ready_pulse", {31'd0, id ? bus.req1_ready : bus.req0_ready}, 32'd1);
    chk("other_ready", {31'd0, id ? bus.req0_ready : bus.req1_ready}, 32'd0);
    step();
    // Disturb the inputs after acceptance; the response must not change.
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_op1 = ~a; bus.req1_op1 = ~a; bus.req0_op2 = ~b; bus.req1_op2 = ~b;
    bus.req0_ctrl = ~c; bus.req1_ctrl = ~c;
    chk("exec_ready", {31'd0, id ? bus.req1_ready : bus.req0_ready}, 32'd0);
    chk("exec_busy", {31'd0, bus.busy}, 32'd1);
    chk("exec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, id});
    chk("rsp_result", bus.rsp_result, exp);
    chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, expz});
    step();
    chk("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("hold_result", bus.rsp_result, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 1'b0; bus.req1_op1 = '0; bus.req1_op2 = '0; bus.req1_ctrl = '0;
    bus.rsp_ready = 1'b1;

    // Reset values, with a pending request that must not be acknowledged
    #2;
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("rst_result", bus.rsp_result, 32'd0);
    chk("rst_zero", {31'd0, bus.rsp_zero}, 32'd0);
    bus.req0_valid = 1'b0;
    step();
    rst_n = 1'b1;

    // Basic add, subtract to zero and wrap-around
    send(1'b0, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0);
    send(1'b1, 32'd3, 32'd3, 3'b001, 32'd0, 1'b1);
    send(1'b1, 32'd0, 32'd1, 3'b001, 32'hFFFF_FFFF, 1'b0);
    // Shifts, increment and its wrap
    send(1'b0, 32'h8000_0001, 32'd0, 3'b101, 32'h0000_0004, 1'b0);
    send(1'b1, 32'h8000_0001, 32'd0, 3'b110, 32'h2000_0000, 1'b0);
    send(1'b0, 32'h8000_0001, 32'd0, 3'b111, 32'h8000_0002, 1'b0);
    send(1'b1, 32'hFFFF_FFFF, 32'd0, 3'b111, 32'h0000_0000, 1'b1);
    // Logic ops
    send(1'b0, 32'h0000_F0F0, 32'h0000_FF00, 3'b010, 32'h0000_F000, 1'b0);
    send(1'b1, 32'h0000_F0F0, 32'h0000_FF00, 3'b011, 32'h0000_FFF0, 1'b0);
    send(1'b0, 32'h0000_F0F0, 32'h0000_FF00, 3'b100, 32'h0000_0FF0, 1'b0);

    // Back-pressure: response held for 5 cycles while req1 keeps requesting
    bus.rsp_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op1 = 32'd9; bus.req1_op2 = 32'd4; bus.req1_ctrl = 3'b001;
    #1;
    chk("stall_accept", {31'd0, bus.req1_ready}, 32'd1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("stall_result", bus.rsp_result, 32'd5);
      chk("stall_id", {31'd0, bus.rsp_id}, 32'd1);
      chk("stall_ready1", {31'd0, bus.req1_ready}, 32'd0);
      chk("stall_busy", {31'd0, bus.busy}, 32'd1);
      step();
    end
    bus.rsp_ready = 1'b1;
    bus.req1_valid = 1'b0;
    step();
    chk("release_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("release_busy", {31'd0, bus.busy}, 32'd0);

    // Reset during EXEC discards the command
    bus.req0_valid = 1'b1; bus.req0_op1 = 32'd5; bus.req0_op2 = 32'd7; bus.req0_ctrl = 3'b000;
    step();
    bus.req0_valid = 1'b0;
    chk("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("abort_result", bus.rsp_result, 32'd0);
    chk("abort_id", {31'd0, bus.rsp_id}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      chk("abort_idle", {31'd0, bus.busy}, 32'd0);
    end

    // Both requesters valid continuously: requester 0 first, then alternating
    bus.req0_valid = 1'b1; bus.req0_op1 = 32'd1;  bus.req0_op2 = 32'd1;  bus.req0_ctrl = 3'b000;
    bus.req1_valid = 1'b1; bus.req1_op1 = 32'd10; bus.req1_op2 = 32'd20; bus.req1_ctrl = 3'b000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", {31'd0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", {31'd0, bus.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      step();
      step();
      chk("rr_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rr_id", {31'd0, bus.rsp_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_result", bus.rsp_result, (k % 2 == 1) ? 32'd30 : 32'd2);
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

Interface
REQ-001 Parameter: n, default 32, operand/result width in bits (n >= 4).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has a command pending.
REQ-005 req0_ready  output  1  requester 0 command accepted this cycle when high with req0_valid.
REQ-006 req0_op1, req0_op2  input  n each  requester 0 operands.
REQ-007 req0_ctrl  input  3  requester 0 operation code.
REQ-008 req1_valid, req1_ready, req1_op1, req1_op2, req1_ctrl  same directions, widths and meanings as REQ-004..007, for requester 1.
REQ-009 rsp_valid  output  1  response held on rsp_* outputs.
REQ-010 rsp_ready  input  1  consumer takes response when high with rsp_valid.
REQ-011 rsp_id  output  1  requester index (0/1) owning the response.
REQ-012 rsp_result  output  n  operation result.
REQ-013 rsp_zero  output  1  high when rsp_result == 0.
REQ-014 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM SHALL have states IDLE, EXEC, RESP; one command in flight at a time.
REQ-016 IDLE: if any reqX_valid, SHALL grant exactly one requester, drive its reqX_ready high combinationally that cycle, capture its op1/op2/ctrl and index, go to EXEC; otherwise stay IDLE.
REQ-017 reqX_ready SHALL be low in EXEC and RESP, and low for any non-granted requester.
REQ-018 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; single valid requester always wins; last-grant pointer updates only on an accepted grant.
REQ-019 EXEC: SHALL compute on captured operands and register result, zero flag and id; go to RESP next cycle.
REQ-020 Op codes: 000 op1+op2; 001 op1-op2; 010 op1&op2; 011 op1|op2; 100 op1^op2; 101 op1<<2; 110 op1>>2 (logical); 111 op1+1.
REQ-021 All arithmetic SHALL be modulo 2^n; carries/borrows discarded; shifted-in bits zero.
REQ-022 RESP: rsp_valid SHALL be high and rsp_id/rsp_result/rsp_zero stable until rsp_valid&rsp_ready; then go to IDLE next cycle with rsp_valid low.
REQ-023 Latency: accept in cycle T -> rsp_valid high from cycle T+2; minimum command spacing 3 cycles (accept, EXEC, RESP with rsp_ready=1).
REQ-024 Input changes on reqX_* after acceptance SHALL NOT affect the in-flight response.
REQ-025 Requester valid dropping before grant SHALL be tolerated; no grant given to a requester with valid low.
REQ-026 rsp_result/rsp_zero/rsp_id SHALL hold last values outside RESP; only rsp_valid qualifies them.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, req0_ready/req1_ready 0, rsp_valid 0, busy 0, rsp_id 0, rsp_result 0, rsp_zero 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-028 Reset asserted in EXEC or RESP SHALL discard the in-flight command with no response produced after release.
REQ-029 First grant possible in the first rising edge with rst_n high and a valid request.

Verification
REQ-030 n=32, only req0 valid, op1=5, op2=7, ctrl=000, rsp_ready=1 -> req0_ready pulse 1 cycle; 2 cycles later rsp_valid, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-031 req1 op1=3, op2=3, ctrl=001 -> rsp_result=0, rsp_zero=1, rsp_id=1; ctrl=001 op1=0 op2=1 -> rsp_result=0xFFFFFFFF, rsp_zero=0.
REQ-032 Both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; each requester served once per 6 cycles.
REQ-033 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and outputs stable, req ready stays 0, busy=1; rsp_ready=1 -> IDLE next cycle.
REQ-034 Ops 101/110/111 with op1=0x80000001 -> 0x00000004, 0x20000000, 0x80000002; op1=0xFFFFFFFF ctrl=111 -> 0, rsp_zero=1.
REQ-035 rst_n pulsed low during EXEC -> outputs reset asynchronously, no rsp_valid afterward; next simultaneous request granted to requester 0.
